// File: rtl/read_fifo.sv
// read_fifo: drains WORDS FIFO words into one LSB-first block presented with valid/ack.
// Define READ_FIFO_BURST_EN to pipeline reads (one word per cycle) instead of REQ/CAP pacing.
module read_fifo #(
  parameter int WIDTH = 32,
  parameter int WORDS = 96
) (
  input  logic                   clk_in,
  input  logic                   rst,
  input  logic                   load_en,
  input  logic                   fifo_empty,
  input  logic [WIDTH-1:0]       fifo_dout,
  output logic                   fifo_rd_en,
  output logic [WIDTH*WORDS-1:0] data_out,
  output logic                   data_valid,
  input  logic                   data_ack,
  output logic                   busy
);
  localparam logic [6:0] N = 7'(WORDS);
  typedef enum logic [1:0] {IDLE, REQ, CAP, DONE} state_t;
  state_t                 r_state;
  state_t                 w_req_next;
  logic [6:0]             r_issued;
  logic [6:0]             r_captured;
  logic [WIDTH*WORDS-1:0] r_asm;
  logic [WIDTH*WORDS-1:0] w_asm_next;
  logic                   w_cap;
  logic                   w_done;
  assign fifo_rd_en = (r_state == REQ) && !fifo_empty && (r_issued < N);
  assign w_asm_next = {fifo_dout, r_asm[WIDTH*WORDS-1:WIDTH]};
  assign w_done     = w_cap && (r_captured == N - 7'd1);
`ifdef READ_FIFO_BURST_EN
  // rd_q marks the cycle in which fifo_dout carries a word we popped
  logic r_rd_q;
  assign w_cap      = (r_state == REQ) && r_rd_q;
  assign w_req_next = REQ;
  always_ff @(posedge clk_in) r_rd_q <= rst ? 1'b0 : fifo_rd_en;
`else
  assign w_cap      = (r_state == CAP);
  assign w_req_next = fifo_rd_en ? CAP : REQ;
`endif
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_state    <= IDLE;
      r_issued   <= '0;
      r_captured <= '0;
      r_asm      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      if (fifo_rd_en) r_issued <= r_issued + 7'd1;
      if (w_cap) begin
        r_asm      <= w_asm_next;
        r_captured <= r_captured + 7'd1;
      end
      if (w_done) begin
        data_out   <= w_asm_next;
        data_valid <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          r_issued   <= '0;
          r_captured <= '0;
          r_state    <= load_en ? REQ : IDLE;
          busy       <= load_en;
        end
        REQ:  r_state <= w_done ? DONE : w_req_next;
        CAP:  r_state <= w_done ? DONE : REQ;
        DONE: if (data_ack) begin
          r_state    <= IDLE;
          data_valid <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_read_fifo.sv
// tb_read_fifo: directed table plus hand sequences against a one-cycle-latency FIFO model.
module tb_read_fifo;
  localparam int W = 32;
  localparam int N = 96;
`ifdef READ_FIFO_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif
  localparam int LAT = BURST ? N + 1 : 2 * N;
  logic           clk_in = 1'b0;
  logic           rst = 1'b1;
  logic           load_en = 1'b0;
  logic           fifo_empty;
  logic [W-1:0]   fifo_dout = '0;
  logic           fifo_rd_en;
  logic [W*N-1:0] data_out;
  logic           data_valid;
  logic           data_ack = 1'b0;
  logic           busy;
  logic [W-1:0]   mem [0:4095];
  int             wr_ptr = 0;
  int             rd_ptr = 0;
  int             underflow = 0;
  int             n_chk = 0;
  int             n_pass = 0;

  read_fifo #(.WIDTH(W), .WORDS(N)) dut (
    .clk_in(clk_in), .rst(rst), .load_en(load_en), .fifo_empty(fifo_empty),
    .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en), .data_out(data_out),
    .data_valid(data_valid), .data_ack(data_ack), .busy(busy));

  always #5 clk_in = ~clk_in;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk_in) begin
    if (fifo_rd_en === 1'b1) begin
      if (wr_ptr == rd_ptr) underflow <= underflow + 1;
      else begin
        fifo_dout <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + 1;
      end
    end
  end

  typedef struct {
    logic rst, load, ack;
    logic rd, bsy, vld;
  } vec_t;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  function automatic logic [W*N-1:0] mk(input int base);
    logic [W*N-1:0] v;
    for (int k = 0; k < N; k++) v[k*W +: W] = W'(base + k);
    return v;
  endfunction

  function automatic int first_bad(input logic [W*N-1:0] a, input logic [W*N-1:0] b);
    for (int k = 0; k < N; k++) if (a[k*W +: W] !== b[k*W +: W]) return k;
    return -1;
  endfunction

  task automatic push(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      mem[wr_ptr] = W'(base + i);
      wr_ptr = wr_ptr + 1;
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic start_load();
    load_en = 1'b1;
    tick();
    load_en = 1'b0;
  endtask

  task automatic wait_valid(output int edges);
    edges = 0;
    while (data_valid !== 1'b1 && edges < 2000) begin
      tick();
      edges++;
    end
  endtask

  task automatic do_ack();
    data_ack = 1'b1;
    tick();
    data_ack = 1'b0;
    chk("ack_valid_low", data_valid, 0);
  endtask

  initial begin
    vec_t vt [9];
    int e, r0, bad;
    logic [W*N-1:0] blk_a;
    vt[0] = '{1, 1, 0, 0, 0, 0};
    vt[1] = '{1, 1, 0, 0, 0, 0};
    vt[2] = '{1, 1, 0, 0, 0, 0};
    vt[3] = '{0, 0, 0, 0, 0, 0};
    vt[4] = '{0, 1, 0, 1, 1, 0};
    vt[5] = '{0, 0, 0, BURST, 1, 0};
    vt[6] = '{0, 0, 0, 1, 1, 0};
    vt[7] = '{1, 1, 0, 0, 0, 0};
    vt[8] = '{0, 0, 1, 0, 0, 0};
    push(16, 500);
    for (int i = 0; i < 9; i++) begin
      rst = vt[i].rst; load_en = vt[i].load; data_ack = vt[i].ack;
      tick();
      chk($sformatf("vec%0d_rd_en", i), fifo_rd_en, vt[i].rd);
      chk($sformatf("vec%0d_busy", i), busy, vt[i].bsy);
      chk($sformatf("vec%0d_valid", i), data_valid, vt[i].vld);
      chk($sformatf("vec%0d_dout_zero", i), data_out == '0, 1);
    end
    rst = 1'b0; load_en = 1'b0; data_ack = 1'b0;
    tick();
    wr_ptr = rd_ptr;

    // full load
    push(N, 1);
    r0 = rd_ptr;
    start_load();
    wait_valid(e);
    chk("full_latency", e, LAT);
    chk("full_block", first_bad(data_out, mk(1)), -1);
    chk("full_reads", rd_ptr - r0, N);
    chk("full_busy", busy, 1);

    // handshake hold with load_en high and words waiting
    push(40, 1001);
    r0 = rd_ptr;
    bad = 0;
    load_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (data_valid !== 1'b1 || busy !== 1'b1 || fifo_rd_en !== 1'b0) bad++;
    end
    chk("hold_valid", bad, 0);
    chk("hold_no_reads", rd_ptr - r0, 0);
    do_ack();
    chk("ack_to_idle_busy", busy, 0);
    chk("ack_held_dout", first_bad(data_out, mk(1)), -1);
    load_en = 1'b0;
    tick();
    chk("ack_stays_idle", busy, 0);
    chk("ack_no_rd", fifo_rd_en, 0);

    // empty stall: 40 words, then 56 more
    start_load();
    repeat (120) tick();
    chk("stall_reads", rd_ptr - r0, 40);
    chk("stall_rd_en", fifo_rd_en, 0);
    chk("stall_valid", data_valid, 0);
    chk("stall_busy", busy, 1);
    chk("stall_dout_old", first_bad(data_out, mk(1)), -1);
    push(56, 1041);
    wait_valid(e);
    chk("stall_valid_seen", data_valid, 1);
    chk("stall_block", first_bad(data_out, mk(1001)), -1);
    chk("stall_underflow", underflow, 0);
    do_ack();

    // mid-load reset after 30 captures
    push(N, 2001);
    start_load();
    repeat (BURST ? 31 : 60) tick();
    chk("mid_busy_before", busy, 1);
    rst = 1'b1;
    tick();
    chk("mid_rst_dout", data_out == '0, 1);
    chk("mid_rst_valid", data_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rd_en", fifo_rd_en, 0);
    rst = 1'b0;
    wr_ptr = rd_ptr;
    tick();
    push(N, 3001);
    r0 = rd_ptr;
    start_load();
    wait_valid(e);
    chk("fresh_latency", e, LAT);
    chk("fresh_block", first_bad(data_out, mk(3001)), -1);
    chk("fresh_reads", rd_ptr - r0, N);
    do_ack();

    // back-to-back blocks
    push(2 * N, 4001);
    r0 = rd_ptr;
    start_load();
    wait_valid(e);
    blk_a = mk(4001);
    chk("b2b_first", first_bad(data_out, blk_a), -1);
    do_ack();
    start_load();
    bad = 0;
    e = 0;
    while (data_valid !== 1'b1 && e < 2000) begin
      if (data_out !== blk_a) bad++;
      tick();
      e++;
    end
    chk("b2b_no_partial", bad, 0);
    chk("b2b_second", first_bad(data_out, mk(4001 + N)), -1);
    chk("b2b_reads", rd_ptr - r0, 2 * N);
    chk("b2b_underflow", underflow, 0);
    do_ack();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/read_fifo.md
# read_fifo

Block-load unpacker for the Toeplitz datapath, and the counterpart of the result-packing writer. It drains 32-bit words from an upstream `fifo_generator` instance (32-bit, standard mode, one-cycle read latency). It assembles `WORDS` consecutive words into one wide vector and presents that vector to the hashing core with a valid/ack handshake. Word 0 lands in bits [31:0]; this is the same LSB-first order the writer uses when it emits a result.

## Interface
Parameters:
- `WIDTH`, 32: FIFO word width.
- `WORDS`, 96: words per block. Output width is `WIDTH*WORDS` = 3072. The counters are 7 bits, so `WORDS` ≤ 127.

Ports (one clock; reset is synchronous and active-high):
- `clk_in` input, 1: clock, rising edge.
- `rst` input, 1: synchronous active-high reset.
- `load_en` input, 1: request one block load; sampled only in IDLE.
- `fifo_empty` input, 1: upstream FIFO empty flag.
- `fifo_dout` input, WIDTH: upstream FIFO data, valid the cycle after `fifo_rd_en`.
- `fifo_rd_en` output, 1: FIFO read strobe, combinational.
- `data_out` output, WIDTH*WORDS: assembled block, registered.
- `data_valid` output, 1: block available; held until acked.
- `data_ack` input, 1: consumer has taken `data_out`.
- `busy` output, 1: high in REQ, CAP and DONE.

## Operation
- States: IDLE, REQ, CAP, DONE.
- Counters: `issued` counts reads requested; `captured` counts words stored. Both are 7-bit and cleared on entering REQ from IDLE.
- Assembly register: a shift register `asm_reg`. Each capture does `asm_reg <= {fifo_dout, asm_reg[W*N-1:W]}`, so after N captures word k sits at [k*W +: W].
- IDLE: the counters are cleared. If `load_en`=1, move to REQ.
- REQ (non-burst build): `fifo_rd_en = !fifo_empty`.
  - If `fifo_rd_en`=1, move to CAP.
  - Otherwise stay in REQ.
- CAP (non-burst build): capture `fifo_dout` and increment `captured`.
  - If `captured` becomes `WORDS`, move to DONE.
  - Otherwise return to REQ.
- DONE: `data_valid`=1. `data_out` is loaded with the completed `asm_reg` on the DONE-entry edge.
  - If `data_ack`=1, move to IDLE on the next edge.
  - `load_en` is ignored in DONE, including when it arrives in the same cycle as `data_ack`; it must be reasserted in IDLE.
- `data_out` holds the last completed block until the next completion or reset. It never shows a partial block.
- Empty stall: while `fifo_empty`=1, `fifo_rd_en`=0 and the block makes no progress. No underflow read is ever issued.
- Reset at any point: state goes to IDLE, `asm_reg`/`data_out`/counters clear to 0, and `data_valid`=0. Words already popped are discarded; the block does not resynchronise the upstream FIFO.
- Reset values: `fifo_rd_en`=0, `data_out`=0, `data_valid`=0, `busy`=0.

## Timing
- Let E0 be the edge that samples `load_en`=1 in IDLE, with the FIFO never empty.
- Non-burst build:
  - Word k is read in the cycle after E(2k) and captured at E(2k+2).
  - `data_valid` rises after E(2*WORDS), which is E192 for the defaults.
  - Throughput is 1 word per 2 cycles.
- Burst build: see Configuration. `data_valid` rises after E(WORDS+1), which is E97.
- Ack latency: `data_ack` high at edge Ea gives IDLE and `data_valid`=0 after Ea. The earliest next `load_en` sample is Ea+1.
- `fifo_rd_en` depends combinationally on `fifo_empty` and state only. There is no path from `fifo_dout`.

## Configuration
- `READ_FIFO_BURST_EN` defined:
  - REQ pipelines reads: `fifo_rd_en = !fifo_empty && (issued < WORDS)`.
  - A registered flag `rd_q` (= `fifo_rd_en` delayed one cycle) qualifies capture of `fifo_dout` in the following cycle.
  - CAP is unused.
  - Move to DONE when `captured` reaches `WORDS`; no read is issued beyond `WORDS`.
  - Empty gaps insert bubbles without losing or duplicating words.
- `READ_FIFO_BURST_EN` undefined: the two-state REQ/CAP pacing above, one read in flight at most.

## Test plan
- Reset: hold `rst`=1 for 3 cycles with the FIFO full. Required: `fifo_rd_en`=0, `data_out`=0, `data_valid`=0, `busy`=0.
- Full load: preload 96 words of value k+1, pulse `load_en`. Required:
  - `data_out[k*32 +: 32]` = k+1 for all k.
  - `data_valid` after E192 (non-burst) or E97 (burst).
  - Exactly 96 `fifo_rd_en` pulses.
- Stall: preload 40 words, load, wait 50 cycles, push 56 more. Required: no `fifo_rd_en` while empty, and the block still assembles correctly.
- Handshake: hold `data_ack`=0 for 20 cycles after valid, with `load_en`=1 throughout. Required:
  - `data_valid` stays high and no reads occur.
  - An ack together with `load_en` gives IDLE, not REQ.
- Mid-load reset: assert `rst` after 30 captures. Required: everything clears. A subsequent load of 96 fresh words is correct and uncontaminated by the 30 earlier words.
- Back-to-back blocks: load 192 words as two blocks. Required: the second `data_out` replaces the first only on its DONE entry, with no partial value visible.
